// File: rtl/factor_search_engine.sv
// Brute-force factoriser: walks odd (a, b) pairs, b outer / a inner, multiplying each
// candidate with a shift-add loop and stopping on the first product equal to the target.
module factor_search_engine #(
  parameter int unsigned A_W = 8,
  parameter int unsigned B_W = 5,
  parameter int unsigned P_W = A_W + B_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [P_W-1:0] target,
  output logic           busy,
  output logic           done,
  output logic           found,
  output logic [A_W-1:0] a_out,
  output logic [B_W-1:0] b_out
);

  localparam int unsigned IW = (B_W > 1) ? $clog2(B_W) : 1;
  localparam logic [IW-1:0]  ILast = IW'(B_W - 1);
  localparam logic [A_W-1:0] AMax  = {A_W{1'b1}};
  localparam logic [B_W-1:0] BMax  = {B_W{1'b1}};

  typedef enum logic [1:0] {StIdle, StMul, StCmp, StDone} state_e;

  state_e         state_q, state_d;
  logic [P_W-1:0] target_q, target_d;
  logic [P_W-1:0] acc_q, acc_d;
  logic [A_W-1:0] a_q, a_d;
  logic [B_W-1:0] b_q, b_d;
  logic [IW-1:0]  i_q, i_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           found_q, found_d;
  logic [A_W-1:0] a_out_q, a_out_d;
  logic [B_W-1:0] b_out_q, b_out_d;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    i_d      = i_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    found_d  = found_q;
    a_out_d  = a_out_q;
    b_out_d  = b_out_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          state_d  = StMul;
          target_d = target;
          a_d      = A_W'(3);
          b_d      = B_W'(3);
          acc_d    = '0;
          i_d      = '0;
          busy_d   = 1'b1;
          found_d  = 1'b0;
          a_out_d  = '0;
          b_out_d  = '0;
        end
      end
      StMul: begin
        if (b_q[i_q]) acc_d = acc_q + (P_W'(a_q) << i_q);
        i_d = i_q + 1'b1;
        if (i_q == ILast) begin
          i_d     = '0;
          state_d = StCmp;
        end
      end
      StCmp: begin
        acc_d = '0;
        i_d   = '0;
        if (acc_q == target_q) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          found_d = 1'b1;
          a_out_d = a_q;
          b_out_d = b_q;
        end else if (a_q == AMax && b_q == BMax) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (a_q == AMax) begin
          state_d = StMul;
          a_d     = A_W'(3);
          b_d     = b_q + B_W'(2);
        end else begin
          state_d = StMul;
          a_d     = a_q + A_W'(2);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      target_q <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      i_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      a_out_q  <= '0;
      b_out_q  <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      i_q      <= i_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      a_out_q  <= a_out_d;
      b_out_q  <= b_out_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign found = found_q;
  assign a_out = a_out_q;
  assign b_out = b_out_q;

endmodule

// File: tb/tb_factor_search_engine.sv
// Bench for factor_search_engine: directed and random targets checked against an
// enumerating reference model for result and done timing.
module tb_factor_search_engine;

  localparam int unsigned A_W = 8;
  localparam int unsigned B_W = 5;
  localparam int unsigned P_W = A_W + B_W;
  localparam int Budget = 20000;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [P_W-1:0] target;
  logic           busy;
  logic           done;
  logic           found;
  logic [A_W-1:0] a_out;
  logic [B_W-1:0] b_out;

  int n_cmp;
  int n_bad;

  factor_search_engine #(.A_W(A_W), .B_W(B_W), .P_W(P_W)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .target (target),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .a_out  (a_out),
    .b_out  (b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: enumerate odd pairs in search order; cost is B_W+1 cycles per candidate.
  function automatic void model(input int t, output bit f, output int a, output int b,
                                output int cyc);
    int k;
    k = 0;
    f = 1'b0;
    a = 0;
    b = 0;
    cyc = 0;
    for (int bb = 3; bb < (1 << B_W); bb += 2) begin
      for (int aa = 3; aa < (1 << A_W); aa += 2) begin
        if (!f && aa * bb == t) begin
          f = 1'b1;
          a = aa;
          b = bb;
          cyc = (B_W + 1) * (k + 1);
        end
        k++;
      end
    end
    if (!f) cyc = (B_W + 1) * k;
  endfunction

  // Caller is positioned at a negedge; returns #1 after the accepting edge.
  task automatic start_search(input string tag, input int t);
    target = P_W'(t);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, ".busy_e0"}, int'(busy), 1);
    check({tag, ".found_clr"}, int'(found), 0);
  endtask

  // Waits for done and checks result, latency and busy duration; returns at the done negedge.
  task automatic finish_search(input string tag, input int t, input bit mess);
    bit f;
    int ea, eb, ecyc, n, busy_n;
    model(t, f, ea, eb, ecyc);
    n = 0;
    busy_n = 1;
    while (1) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) break;
      if (busy) busy_n++;
      start = mess && (n == 100 || n == 2000);
      if (mess && (n == 100 || n == 3000)) target = P_W'($urandom);
      if (n >= Budget) break;
    end
    start = 1'b0;
    check({tag, ".done_seen"}, int'(done), 1);
    check({tag, ".cycles"}, n, ecyc);
    check({tag, ".busy_cycles"}, busy_n, ecyc);
    check({tag, ".busy_at_done"}, int'(busy), 0);
    check({tag, ".found"}, int'(found), int'(f));
    check({tag, ".a_out"}, int'(a_out), ea);
    check({tag, ".b_out"}, int'(b_out), eb);
  endtask

  task automatic check_pulse_end(input string tag);
    int fnd, a, b;
    fnd = int'(found);
    a = int'(a_out);
    b = int'(b_out);
    @(negedge clk);
    check({tag, ".done_1cyc"}, int'(done), 0);
    check({tag, ".hold_a"}, int'(a_out), a);
    check({tag, ".hold_b"}, int'(b_out), b);
    check({tag, ".hold_f"}, int'(found), fnd);
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    target = '0;
    repeat (3) @(negedge clk);
    check("rst.busy", int'(busy), 0);
    check("rst.done", int'(done), 0);
    check("rst.found", int'(found), 0);
    check("rst.a", int'(a_out), 0);
    check("rst.b", int'(b_out), 0);
    rst_n = 1'b1;
    @(negedge clk);

    start_search("t437", 437);
    finish_search("t437", 437, 1'b0);
    check("t437.prod", int'(a_out) * int'(b_out), 437);
    check_pulse_end("t437");

    start_search("t9", 9);
    finish_search("t9", 9, 1'b0);
    check_pulse_end("t9");

    start_search("t31", 31);
    finish_search("t31", 31, 1'b0);

    @(negedge clk);
    start_search("t1", 1);
    finish_search("t1", 1, 1'b0);

    @(negedge clk);
    start_search("t7905", 7905);
    finish_search("t7905", 7905, 1'b0);
    // Back-to-back start accepted in the DONE cycle.
    start_search("t15", 15);
    check("t15.a_clr", int'(a_out), 0);
    check("t15.b_clr", int'(b_out), 0);
    finish_search("t15", 15, 1'b0);

    // Mid-search asynchronous reset.
    @(negedge clk);
    start_search("rst_mid", 437);
    repeat (2999) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid.busy", int'(busy), 0);
    check("rst_mid.done", int'(done), 0);
    check("rst_mid.a", int'(a_out), 0);
    check("rst_mid.found", int'(found), 0);
    repeat (2) begin
      @(negedge clk);
      check("rst_mid.no_done", int'(done), 0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_mid.idle_done", int'(done), 0);
      check("rst_mid.idle_busy", int'(busy), 0);
    end
    start_search("t437b", 437);
    finish_search("t437b", 437, 1'b0);

    @(negedge clk);
    start_search("ignore", 437);
    finish_search("ignore", 437, 1'b1);

    for (int r = 0; r < 8; r++) begin
      int t;
      t = (3 + 2 * int'($urandom_range(0, 126))) * (3 + 2 * int'($urandom_range(0, 2)));
      if (r == 7) t = int'($urandom_range(0, 300)) * 2;  // even: always a miss
      if (r == 7) t = 2 * int'($urandom_range(2, 7)) + 1;  // small odd
      @(negedge clk);
      start_search($sformatf("rnd%0d", r), t);
      finish_search($sformatf("rnd%0d", r), t, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
